// File: rtl/rvx_gpio_input_filter.sv
// GPIO input conditioning: two-flop synchroniser, prescaled per-pin debounce,
// edge-to-interrupt capture and a small CSR block on the RVX register interface.
module rvx_gpio_input_filter #(
  parameter int unsigned GPIO_WIDTH     = 32,
  parameter int unsigned FILTER_SAMPLES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [4:0]            rw_address,
  output logic [31:0]           read_data,
  input  logic                  read_request,
  output logic                  read_response,
  input  logic [31:0]           write_data,
  input  logic [3:0]            write_strobe,
  input  logic                  write_request,
  output logic                  write_response,
  input  logic [GPIO_WIDTH-1:0] gpio_raw,
  output logic [GPIO_WIDTH-1:0] gpio_filtered,
  output logic                  irq
);

  localparam logic [4:0] AddrFiltered = 5'h00;
  localparam logic [4:0] AddrPrescale = 5'h04;
  localparam logic [4:0] AddrRiseEn   = 5'h08;
  localparam logic [4:0] AddrFallEn   = 5'h0C;
  localparam logic [4:0] AddrPending  = 5'h10;

  localparam logic [3:0] CntMax = 4'(FILTER_SAMPLES - 1);

  // Handshake and read path
  logic [31:0] read_data_q, read_data_d;
  logic        read_response_q;
  logic        write_response_q;

  // Synchroniser and debounce state
  logic [GPIO_WIDTH-1:0] s1_q, s2_q;
  logic [GPIO_WIDTH-1:0] filtered_q, filtered_d;
  logic [3:0]            cnt_q [GPIO_WIDTH];
  logic [3:0]            cnt_d [GPIO_WIDTH];

  // Prescaler
  logic [15:0] presc_cnt_q, presc_cnt_d;
  logic        tick;

  // Control/status registers
  logic [15:0]           prescale_q, prescale_d;
  logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
  logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
  logic [GPIO_WIDTH-1:0] pending_q, pending_d;

  // Write decode
  logic        strobe_ok;
  logic        write_accept;
  logic [31:0] byte_mask;
  logic [31:0] wdata_masked;
  logic        wr_prescale, wr_rise_en, wr_fall_en, wr_pending;

  logic [GPIO_WIDTH-1:0] rise, fall, edge_set;

  always_comb begin
    strobe_ok    = (write_strobe == 4'b1111) || (write_strobe == 4'b0011) ||
                   (write_strobe == 4'b0001);
    write_accept = write_request && strobe_ok;
    byte_mask    = {{8{write_strobe[3]}}, {8{write_strobe[2]}},
                    {8{write_strobe[1]}}, {8{write_strobe[0]}}};
    wdata_masked = write_data & byte_mask;
    wr_prescale  = write_accept && (rw_address == AddrPrescale);
    wr_rise_en   = write_accept && (rw_address == AddrRiseEn);
    wr_fall_en   = write_accept && (rw_address == AddrFallEn);
    wr_pending   = write_accept && (rw_address == AddrPending);
  end

  // Prescaler: tick on match, then wrap; a PRESCALE write restarts the count.
  always_comb begin
    tick        = (presc_cnt_q == prescale_q);
    presc_cnt_d = tick ? 16'h0000 : presc_cnt_q + 16'h0001;
    if (wr_prescale) begin
      presc_cnt_d = 16'h0000;
    end
  end

  always_comb begin
    filtered_d = filtered_q;
    for (int i = 0; i < int'(GPIO_WIDTH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (s2_q[i] == filtered_q[i]) begin
          cnt_d[i] = 4'h0;
        end else if (cnt_q[i] == CntMax) begin
          filtered_d[i] = s2_q[i];
          cnt_d[i]      = 4'h0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'h1;
        end
      end
    end
  end

  // Edge capture happens on the same edge that updates the filtered value.
  always_comb begin
    rise     = filtered_d & ~filtered_q;
    fall     = ~filtered_d & filtered_q;
    edge_set = (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_comb begin
    prescale_d = prescale_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    pending_d  = pending_q;
    if (wr_prescale) begin
      prescale_d = (prescale_q & ~byte_mask[15:0]) | wdata_masked[15:0];
    end
    if (wr_rise_en) begin
      rise_en_d = (rise_en_q & ~byte_mask[GPIO_WIDTH-1:0]) | wdata_masked[GPIO_WIDTH-1:0];
    end
    if (wr_fall_en) begin
      fall_en_d = (fall_en_q & ~byte_mask[GPIO_WIDTH-1:0]) | wdata_masked[GPIO_WIDTH-1:0];
    end
    if (wr_pending) begin
      pending_d = pending_q & ~wdata_masked[GPIO_WIDTH-1:0];
    end
    // New edges win over a simultaneous clear.
    pending_d = pending_d | edge_set;
  end

  always_comb begin
    read_data_d = read_data_q;
    if (read_request) begin
      read_data_d = 32'h0;
      unique case (rw_address)
        AddrFiltered: read_data_d[GPIO_WIDTH-1:0] = filtered_q;
        AddrPrescale: read_data_d[15:0]           = prescale_q;
        AddrRiseEn:   read_data_d[GPIO_WIDTH-1:0] = rise_en_q;
        AddrFallEn:   read_data_d[GPIO_WIDTH-1:0] = fall_en_q;
        AddrPending:  read_data_d[GPIO_WIDTH-1:0] = pending_q;
        default:      read_data_d                 = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q      <= 32'h0;
      read_response_q  <= 1'b0;
      write_response_q <= 1'b0;
      s1_q             <= '0;
      s2_q             <= '0;
      filtered_q       <= '0;
      presc_cnt_q      <= 16'h0;
      prescale_q       <= 16'h0;
      rise_en_q        <= '0;
      fall_en_q        <= '0;
      pending_q        <= '0;
      for (int i = 0; i < int'(GPIO_WIDTH); i++) begin
        cnt_q[i] <= 4'h0;
      end
    end else begin
      read_data_q      <= read_data_d;
      read_response_q  <= read_request;
      write_response_q <= write_request;
      s1_q             <= gpio_raw;
      s2_q             <= s1_q;
      filtered_q       <= filtered_d;
      presc_cnt_q      <= presc_cnt_d;
      prescale_q       <= prescale_d;
      rise_en_q        <= rise_en_d;
      fall_en_q        <= fall_en_d;
      pending_q        <= pending_d;
      for (int i = 0; i < int'(GPIO_WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign read_data      = read_data_q;
  assign read_response  = read_response_q;
  assign write_response = write_response_q;
  assign gpio_filtered  = filtered_q;
  assign irq            = |pending_q;

endmodule

// File: tb/tb_rvx_gpio_input_filter.sv
// Scoreboard bench for rvx_gpio_input_filter: register reads are checked through
// an expected-value queue, pin and interrupt behaviour by cycle-exact checks.
module tb_rvx_gpio_input_filter;

  localparam int unsigned W = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [4:0]    rw_address = '0;
  logic [31:0]   read_data;
  logic          read_request = 1'b0;
  logic          read_response;
  logic [31:0]   write_data = '0;
  logic [3:0]    write_strobe = '0;
  logic          write_request = 1'b0;
  logic          write_response;
  logic [W-1:0]  gpio_raw = '0;
  logic [W-1:0]  gpio_filtered;
  logic          irq;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] sb_q[$];

  rvx_gpio_input_filter #(
    .GPIO_WIDTH    (W),
    .FILTER_SAMPLES(4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rw_address    (rw_address),
    .read_data     (read_data),
    .read_request  (read_request),
    .read_response (read_response),
    .write_data    (write_data),
    .write_strobe  (write_strobe),
    .write_request (write_request),
    .write_response(write_response),
    .gpio_raw      (gpio_raw),
    .gpio_filtered (gpio_filtered),
    .irq           (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic reg_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    rw_address    = addr;
    write_data    = data;
    write_strobe  = strb;
    write_request = 1'b1;
    step(1);
    write_request = 1'b0;
    write_strobe  = 4'h0;
    check("write_ack", {31'h0, write_response}, 32'h1);
  endtask

  task automatic reg_read(input logic [4:0] addr, input logic [31:0] exp);
    rw_address   = addr;
    read_request = 1'b1;
    sb_q.push_back(exp);
    step(1);
    read_request = 1'b0;
    step(1);
  endtask

  // Read responses are compared against the queue between edges.
  always @(negedge clock) begin
    if (reset_n && read_response) begin
      if (sb_q.size() == 0) check("sb_underflow", 32'h1, 32'h0);
      else check("read_data", read_data, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("rst_filtered", gpio_filtered, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rresp", {31'h0, read_response}, 32'h0);
    check("rst_rdata", read_data, 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    step(2);
    reg_read(5'h04, 32'h0);
    reg_read(5'h10, 32'h0);

    // Latency: raw set before edge k, filtered visible after edge k+5.
    gpio_raw = 32'h1;
    step(5);
    check("lat_before", gpio_filtered, 32'h0);
    step(1);
    check("lat_after", gpio_filtered, 32'h1);
    reg_read(5'h00, 32'h1);

    // Glitch of 3 samples is rejected, 4 samples accepted.
    gpio_raw = 32'h9;
    step(3);
    gpio_raw = 32'h1;
    step(10);
    check("glitch3", gpio_filtered, 32'h1);
    gpio_raw = 32'h9;
    step(4);
    gpio_raw = 32'h1;
    step(2);
    check("pulse4_rise", gpio_filtered, 32'h9);
    step(10);
    check("pulse4_fall", gpio_filtered, 32'h1);
    reg_read(5'h10, 32'h0);

    // Prescaled debounce: ticks every 10 cycles from the write.
    reg_write(5'h04, 32'h9, 4'b1111);
    gpio_raw = 32'h0;
    step(39);
    check("presc_before", gpio_filtered, 32'h1);
    step(1);
    check("presc_after", gpio_filtered, 32'h0);
    gpio_raw = 32'h1;
    step(15);
    reg_write(5'h04, 32'h9, 4'b1111);
    step(29);
    check("restart_before", gpio_filtered, 32'h0);
    step(1);
    check("restart_after", gpio_filtered, 32'h1);
    reg_write(5'h04, 32'hABCD_0000, 4'b1111);
    reg_read(5'h04, 32'h0);
    reg_write(5'h14, 32'hFFFF_FFFF, 4'b1111);
    reg_read(5'h14, 32'h0);

    // Edge capture and W1C.
    gpio_raw = 32'h2;
    step(10);
    check("pre_irq", {31'h0, irq}, 32'h0);
    reg_write(5'h08, 32'h1, 4'b1111);
    reg_write(5'h0C, 32'h2, 4'b1111);
    reg_read(5'h08, 32'h1);
    gpio_raw = 32'h1;
    step(10);
    check("irq_set", {31'h0, irq}, 32'h1);
    reg_read(5'h10, 32'h3);
    reg_write(5'h10, 32'h1, 4'b1111);
    reg_read(5'h10, 32'h2);
    reg_write(5'h10, 32'hFFFF_FFFF, 4'b0100);
    reg_read(5'h10, 32'h2);
    check("irq_hold", {31'h0, irq}, 32'h1);
    reg_write(5'h10, 32'h2, 4'b1111);
    check("irq_clr", {31'h0, irq}, 32'h0);

    // Set beats a simultaneous clear on the same bit.
    gpio_raw = 32'h0;
    step(10);
    reg_read(5'h10, 32'h0);
    gpio_raw = 32'h1;
    step(5);
    reg_write(5'h10, 32'h1, 4'b1111);
    check("set_vs_clr_irq", {31'h0, irq}, 32'h1);
    reg_read(5'h10, 32'h1);

    // Fill PENDING, then reset asynchronously mid-debounce.
    reg_write(5'h08, 32'hF, 4'b1111);
    gpio_raw = 32'hF;
    step(10);
    reg_read(5'h10, 32'hF);
    gpio_raw = 32'h0;
    step(3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_filtered", gpio_filtered, 32'h0);
    check("arst_irq", {31'h0, irq}, 32'h0);
    check("arst_rdata", read_data, 32'h0);
    gpio_raw = 32'hFFFF_FFFF;
    step(3);
    @(posedge clock);
    #1 reset_n = 1'b1;
    step(5);
    check("post_rst_before", gpio_filtered, 32'h0);
    step(1);
    check("post_rst_after", gpio_filtered, 32'hFFFF_FFFF);
    step(5);
    check("post_rst_irq", {31'h0, irq}, 32'h0);
    reg_read(5'h10, 32'h0);
    reg_read(5'h08, 32'h0);
    step(2);
    check("sb_empty", sb_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rvx_gpio_input_filter.md
Name: rvx_gpio_input_filter

Overview:
Input conditioning stage directly upstream of rvx_gpio. It synchronises raw pad inputs, debounces each pin with a programmable sample rate, and drives the filtered vector into the gpio_input port of rvx_gpio. It also detects rising and falling edges on the filtered inputs and raises a level interrupt. Its control and status registers use the same register read/write interface as the other RVX peripherals.

Parameters:
GPIO_WIDTH, 32, number of pins; legal range 1..32.
FILTER_SAMPLES, 4, consecutive differing samples needed to accept a new level; legal range 2..15.

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
rw_address  input  5  register byte address
read_data  output  32  read data; valid with read_response
read_request  input  1  read strobe, one cycle
read_response  output  1  read acknowledge
write_data  input  32  write data
write_strobe  input  4  byte strobes
write_request  input  1  write strobe, one cycle
write_response  output  1  write acknowledge
gpio_raw  input  GPIO_WIDTH  asynchronous pad inputs
gpio_filtered  output  GPIO_WIDTH  debounced inputs; connects to rvx_gpio gpio_input
irq  output  1  interrupt; high while any PENDING bit is set

Behaviour:
- Reset: asynchronous, active-low. All flops clear to 0: read_data, read_response, write_response, synchroniser, gpio_filtered, per-pin counters, prescaler, PRESCALE, RISE_EN, FALL_EN, PENDING. irq is therefore 0.
- Handshake:
  - read_response <= read_request and write_response <= write_request, one cycle later, unconditionally.
  - read_data is registered when read_request is high and holds its value otherwise.
- Writes:
  - Accepted only when write_request=1 and write_strobe is 4'b1111, 4'b0011 or 4'b0001.
  - Any other strobe is acknowledged but ignored.
  - Bits above GPIO_WIDTH are ignored on write and read as 0.
- Register map (byte offsets):
  - 0x00 FILTERED: RO, reads gpio_filtered.
  - 0x04 PRESCALE: RW, bits [15:0] used, upper bits read 0.
  - 0x08 RISE_EN: RW.
  - 0x0C FALL_EN: RW.
  - 0x10 PENDING: read; writing 1 clears that bit (W1C).
  - Other addresses read 0; writes to them are ignored.
- Synchroniser: two-flop chain per pin, gpio_raw -> s1 -> s2.
- Prescaler:
  - 16-bit counter. tick=1 in a cycle where counter==PRESCALE; the counter then wraps to 0, otherwise it increments.
  - PRESCALE=0 gives a tick every cycle.
  - An accepted write to PRESCALE also clears the counter that cycle.
- Per-pin debounce, on tick only (values hold between ticks):
  - If s2[i]==gpio_filtered[i], clear cnt[i].
  - Else if cnt[i]==FILTER_SAMPLES-1, set gpio_filtered[i]<=s2[i] and clear cnt[i].
  - Else increment cnt[i].
  - Counter width is 4 bits.
  - A glitch shorter than FILTER_SAMPLES ticks never reaches gpio_filtered.
- Latency with PRESCALE=0:
  - A gpio_raw change set up before edge k appears on gpio_filtered after edge k+1+FILTER_SAMPLES.
  - Default: 6 edges.
- Edge detection (same cycle as the filtered update):
  - rise[i] = filtered 0->1; fall[i] = filtered 1->0.
  - Set PENDING[i] when (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
  - Set has priority over a simultaneous W1C on the same bit.
  - Changing RISE_EN/FALL_EN never sets or clears PENDING.
- irq = |PENDING, registered-free OR of PENDING flops, so irq rises the cycle after the bit is set.
- Reset mid-debounce discards partial counts. After reset release, pins held high rise on gpio_filtered after the normal latency. With enables at 0, no PENDING bit is set.

Test Plan:
- Reset, PRESCALE=0, gpio_raw 0->0x0000_0001 at edge k -> gpio_filtered=0x1 exactly after edge k+5; FILTERED read (addr 0x00) returns 0x0000_0001 with read_response one cycle after read_request.
- PRESCALE=0, pulse gpio_raw[3] high for 3 cycles -> gpio_filtered[3] stays 0, PENDING stays 0; pulse of 4+ cycles -> gpio_filtered[3] rises.
- PRESCALE=9, step gpio_raw[0] -> filtered changes after 4 ticks (~40 cycles, not earlier than 30 after sync); write PRESCALE mid-count restarts the prescaler from 0.
- RISE_EN=0x1, FALL_EN=0x2; rise on pin0 and fall on pin1 -> PENDING=0x3, irq=1; write 0x1 to 0x10 -> PENDING=0x2; write 0x2 -> irq=0; write with strobe 4'b0100 -> acknowledged, PENDING unchanged.
- Rise on pin0 in the same cycle as W1C of bit0 -> PENDING[0]=1 after that edge.
- Assert reset_n low asynchronously mid-debounce and with PENDING=0xF -> all outputs 0 immediately; after release, gpio_raw held 0xFFFF_FFFF -> gpio_filtered=0xFFFF_FFFF after latency, irq stays 0.
